riscv_test_result_monitor: RTL and testbench
============================================

Name: riscv_test_result_monitor

Overview:
Downstream observer of the core during riscv-tests runs. It consumes the core's retirement stream (PC plus the current gp/x3 value) and detects arrival at the write_tohost loop. It decodes the riscv-tests pass/fail convention and watches for global timeout and retirement stalls. It presents a sticky, registered verdict that the simulation top uses to write the result file and end the run.

Parameters:
TOHOST_PC, 32'h0000_0044, PC of the write_tohost loop; a retirement here ends the test.
TIMEOUT, 5000, max cycles in RUN before the TIMEOUT verdict.
STALL_LIMIT, 256, max consecutive cycles without retirement before the HANG verdict.
CW, 32, width of cycle/retire counters.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
retire_valid  in  1  one instruction retired this cycle
retire_pc  in  32  PC of the retired instruction
gp_value  in  32  architectural x3 (gp) as seen after the retiring instruction
done  out  1  verdict reached (sticky)
passed  out  1  verdict = PASS
failed  out  1  verdict = FAIL
timed_out  out  1  verdict = TIMEOUT or HANG
hung  out  1  verdict = HANG (subset of timed_out)
fail_testnum  out  31  gp_value[31:1] captured on FAIL, else 0
cycle_count  out  CW  cycles spent in RUN
retire_count  out  CW  retirements counted in RUN

Behaviour:
- Reset (rst==0 at a rising edge): state=RUN; all outputs 0; counters 0; stall counter 0. Reset wins over every other event, including mid-verdict; a completed verdict is cleared.
- States: RUN, PASS, FAIL, TIMEOUT, HANG. PASS/FAIL/TIMEOUT/HANG are terminal until reset.
- RUN, each cycle:
  - cycle_count += 1, saturating at 2^CW-1.
  - If retire_valid: retire_count += 1 (saturating) and stall counter cleared; else stall counter += 1.
- Hit = retire_valid && retire_pc==TOHOST_PC.
  - On hit: if gp_value==32'h1, go to PASS. Otherwise go to FAIL and capture fail_testnum=gp_value[31:1]. This includes gp==0 and even gp values (malformed, still FAIL).
- Timeout: if there is no hit and cycle_count == TIMEOUT-1 (the cycle that would make it TIMEOUT), go to TIMEOUT.
- Stall: if there is no hit and the stall counter == STALL_LIMIT-1 with retire_valid==0, go to HANG.
- Priority in the same cycle: hit > HANG > TIMEOUT.
- Latency: verdict outputs are registered and assert on the edge that samples the hit/limit condition. They are visible the following cycle.
- Output decode: done = state!=RUN. timed_out = TIMEOUT|HANG. The remaining flags are one-hot per state.
- Counters freeze (hold value) in terminal states. Inputs are ignored there, including later hits with different gp.
- A retirement on the hit cycle is counted in retire_count (counters update on that edge).
- Retirements are never counted while rst==0.

Decomposition:
- Shared package riscv_test_pkg:
  - state enum (RUN, PASS, FAIL, TIMEOUT, HANG)
  - PASS_GP constant 32'h1
  - default TOHOST_PC
  - riscv-tests ABI constants (gp = x3, a7 = 93 exit call) for reuse by other bench monitors.
- One natural sub-module: sat_counter (width-parameterised, enable + clear, saturating increment). Instantiated for cycle_count, retire_count and the stall counter.

Test Plan:
- Retire PCs 0x0,0x4,...,0x40 one per cycle, then 0x44 with gp=1 -> next cycle done=1, passed=1, retire_count=18, cycle_count=18; later hit with gp=7 leaves outputs unchanged.
- Hit at 0x44 with gp=32'h0000_000B -> failed=1, fail_testnum=5, passed=0, timed_out=0.
- Retire every cycle, never at 0x44, TIMEOUT=50 -> timed_out=1, hung=0 after 50 cycles, cycle_count=50 and frozen thereafter.
- Hold retire_valid=0 from reset, STALL_LIMIT=8, TIMEOUT=8 -> hung=1 and timed_out=1 (HANG beats TIMEOUT), cycle_count=8; a hit with gp=1 on cycle 8 instead -> passed=1.
- Reach PASS, drive rst=0 for one edge -> all outputs 0 next cycle; new run with gp=3 hit -> failed=1, fail_testnum=1.
- Assert rst=0 between clock edges only (released before the edge) -> no state change, confirming synchronous reset.

Source files
------------

// File: rtl/riscv_test_pkg.sv
// rtl/riscv_test_pkg.sv - shared verdict states and riscv-tests ABI constants
package riscv_test_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_t;

  // riscv-tests writes 1 to gp on success, (testnum << 1) | 1 on failure
  localparam logic [31:0] PASS_GP           = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_TOHOST_PC = 32'h0000_0044;

  localparam logic [4:0]  ABI_GP_REG = 5'd3;
  localparam logic [4:0]  ABI_A7_REG = 5'd17;
  localparam logic [31:0] ECALL_EXIT = 32'd93;

  function automatic logic is_pass_gp(input logic [31:0] gp);
    return gp == PASS_GP;
  endfunction

endpackage

// File: rtl/riscv_test_result_monitor_sat_counter.sv
// rtl/riscv_test_result_monitor_sat_counter.sv - saturating up-counter with clear and enable
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/riscv_test_result_monitor.sv
// rtl/riscv_test_result_monitor.sv - riscv-tests pass/fail/timeout/hang verdict from the retirement stream
module riscv_test_result_monitor
  import riscv_test_pkg::*;
#(
  parameter logic [31:0] TOHOST_PC   = DEFAULT_TOHOST_PC,
  parameter int          TIMEOUT     = 5000,
  parameter int          STALL_LIMIT = 256,
  parameter int          CW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          retire_valid,
  input  logic [31:0]   retire_pc,
  input  logic [31:0]   gp_value,
  output logic          done,
  output logic          passed,
  output logic          failed,
  output logic          timed_out,
  output logic          hung,
  output logic [30:0]   fail_testnum,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] retire_count
);

  // A limit beyond what CW bits can count is never reached; the counter saturates first
  localparam longint unsigned CNT_MAX =
    (CW >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  localparam bit TIMEOUT_REACHABLE = (TIMEOUT >= 1) && (64'(TIMEOUT - 1) <= CNT_MAX);
  localparam bit STALL_REACHABLE   = (STALL_LIMIT >= 1) && (64'(STALL_LIMIT - 1) <= CNT_MAX);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] STALL_LAST   = CW'(STALL_LIMIT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] stall_count;
  logic          in_run;
  logic          hit;
  logic          stall_now;
  logic          timeout_now;

  assign in_run      = (state == ST_RUN);
  assign hit         = retire_valid && (retire_pc == TOHOST_PC);
  assign stall_now   = STALL_REACHABLE && !retire_valid && (stall_count == STALL_LAST);
  assign timeout_now = TIMEOUT_REACHABLE && (cycle_count == TIMEOUT_LAST);

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (in_run),
    .count (cycle_count)
  );

  sat_counter #(.W(CW)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (in_run && retire_valid),
    .count (retire_count)
  );

  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (in_run && retire_valid),
    .en    (in_run && !retire_valid),
    .count (stall_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Same-cycle priority: tohost hit, then stall, then global timeout
  always_comb begin
    state_nxt = state;
    if (state == ST_RUN) begin
      if (hit) begin
        state_nxt = is_pass_gp(gp_value) ? ST_PASS : ST_FAIL;
      end else if (stall_now) begin
        state_nxt = ST_HANG;
      end else if (timeout_now) begin
        state_nxt = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fail_testnum <= '0;
    end else if (in_run && hit && !is_pass_gp(gp_value)) begin
      fail_testnum <= gp_value[31:1];
    end
  end

  assign done      = (state != ST_RUN);
  assign passed    = (state == ST_PASS);
  assign failed    = (state == ST_FAIL);
  assign hung      = (state == ST_HANG);
  assign timed_out = (state == ST_TIMEOUT) || (state == ST_HANG);

endmodule

// File: tb/tb_riscv_test_result_monitor.sv
// tb/tb_riscv_test_result_monitor.sv - directed self-checking bench for riscv_test_result_monitor
module tb_riscv_test_result_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = 32'h0;
  logic [31:0] gp_value = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // default parameters
  logic        d0_done, d0_passed, d0_failed, d0_timed_out, d0_hung;
  logic [30:0] d0_fnum;
  logic [31:0] d0_cyc, d0_ret;
  logic [4:0]  d0_flags;
  assign d0_flags = {d0_done, d0_passed, d0_failed, d0_timed_out, d0_hung};

  // TIMEOUT = 50
  logic        t_done, t_passed, t_failed, t_timed_out, t_hung;
  logic [30:0] t_fnum;
  logic [31:0] t_cyc, t_ret;
  logic [4:0]  t_flags;
  assign t_flags = {t_done, t_passed, t_failed, t_timed_out, t_hung};

  // TIMEOUT = STALL_LIMIT = 8
  logic        h_done, h_passed, h_failed, h_timed_out, h_hung;
  logic [30:0] h_fnum;
  logic [31:0] h_cyc, h_ret;
  logic [4:0]  h_flags;
  assign h_flags = {h_done, h_passed, h_failed, h_timed_out, h_hung};

  // 4-bit counters, limits unreachable
  logic        s_done, s_passed, s_failed, s_timed_out, s_hung;
  logic [30:0] s_fnum;
  logic [3:0]  s_cyc, s_ret;
  logic [4:0]  s_flags;
  assign s_flags = {s_done, s_passed, s_failed, s_timed_out, s_hung};

  riscv_test_result_monitor u_d0 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .done(d0_done), .passed(d0_passed), .failed(d0_failed), .timed_out(d0_timed_out), .hung(d0_hung),
    .fail_testnum(d0_fnum), .cycle_count(d0_cyc), .retire_count(d0_ret)
  );

  riscv_test_result_monitor #(.TIMEOUT(50)) u_t50 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .done(t_done), .passed(t_passed), .failed(t_failed), .timed_out(t_timed_out), .hung(t_hung),
    .fail_testnum(t_fnum), .cycle_count(t_cyc), .retire_count(t_ret)
  );

  riscv_test_result_monitor #(.TIMEOUT(8), .STALL_LIMIT(8)) u_h8 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .done(h_done), .passed(h_passed), .failed(h_failed), .timed_out(h_timed_out), .hung(h_hung),
    .fail_testnum(h_fnum), .cycle_count(h_cyc), .retire_count(h_ret)
  );

  riscv_test_result_monitor #(.TIMEOUT(100), .STALL_LIMIT(100), .CW(4)) u_s4 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .done(s_done), .passed(s_passed), .failed(s_failed), .timed_out(s_timed_out), .hung(s_hung),
    .fail_testnum(s_fnum), .cycle_count(s_cyc), .retire_count(s_ret)
  );

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] gp);
    retire_valid = v;
    retire_pc    = pc;
    gp_value     = gp;
    @(posedge clk);
    #1;
  endtask

  // A tohost hit with gp=1 is driven during reset; it must not be seen
  task automatic do_reset();
    rst = 1'b0;
    step(1'b1, 32'h44, 32'h1);
    rst = 1'b1;
    retire_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (d0_flags !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", d0_flags); end
    n_checks++;
    if (d0_cyc !== 32'd0 || d0_ret !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts: got cyc=%0d ret=%0d want 0/0", d0_cyc, d0_ret);
    end
    n_checks++;
    if (d0_fnum !== 31'd0) begin n_fail++; $display("FAIL reset_fnum: got %0d want 0", d0_fnum); end
    n_checks++;
    if (h_flags !== 5'b00000 || t_flags !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags_other: got h=%b t=%b want 00000", h_flags, t_flags);
    end
  endtask

  task automatic test_pass();
    do_reset();
    for (int i = 0; i <= 16; i++) step(1'b1, 32'(i * 4), 32'h0);
    n_checks++;
    if (d0_flags !== 5'b00000) begin n_fail++; $display("FAIL pass_pre_flags: got %b want 00000", d0_flags); end
    step(1'b1, 32'h44, 32'h1);
    n_checks++;
    if (d0_flags !== 5'b11000) begin n_fail++; $display("FAIL pass_flags: got %b want 11000", d0_flags); end
    n_checks++;
    if (d0_cyc !== 32'd18 || d0_ret !== 32'd18) begin
      n_fail++; $display("FAIL pass_counts: got cyc=%0d ret=%0d want 18/18", d0_cyc, d0_ret);
    end
    step(1'b1, 32'h44, 32'h7);
    step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (d0_flags !== 5'b11000 || d0_fnum !== 31'd0) begin
      n_fail++; $display("FAIL pass_sticky: got flags=%b fnum=%0d want 11000/0", d0_flags, d0_fnum);
    end
    n_checks++;
    if (d0_cyc !== 32'd18 || d0_ret !== 32'd18) begin
      n_fail++; $display("FAIL pass_frozen: got cyc=%0d ret=%0d want 18/18", d0_cyc, d0_ret);
    end
  endtask

  task automatic test_fail();
    do_reset();
    step(1'b1, 32'h44, 32'h0000_000B);
    n_checks++;
    if (d0_flags !== 5'b10100 || d0_fnum !== 31'd5) begin
      n_fail++; $display("FAIL fail_gp11: got flags=%b fnum=%0d want 10100/5", d0_flags, d0_fnum);
    end
    n_checks++;
    if (d0_cyc !== 32'd1 || d0_ret !== 32'd1) begin
      n_fail++; $display("FAIL fail_counts: got cyc=%0d ret=%0d want 1/1", d0_cyc, d0_ret);
    end
    do_reset();
    step(1'b1, 32'h44, 32'h0);
    n_checks++;
    if (d0_flags !== 5'b10100 || d0_fnum !== 31'd0) begin
      n_fail++; $display("FAIL fail_gp0: got flags=%b fnum=%0d want 10100/0", d0_flags, d0_fnum);
    end
    do_reset();
    step(1'b0, 32'h44, 32'h1);
    step(1'b1, 32'h44, 32'h8000_0002);
    n_checks++;
    if (d0_flags !== 5'b10100 || d0_fnum !== 31'h4000_0001) begin
      n_fail++; $display("FAIL fail_gp_even: got flags=%b fnum=%h want 10100/40000001", d0_flags, d0_fnum);
    end
    n_checks++;
    if (d0_cyc !== 32'd2 || d0_ret !== 32'd1) begin
      n_fail++; $display("FAIL fail_even_counts: got cyc=%0d ret=%0d want 2/1", d0_cyc, d0_ret);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 49; i++) step(1'b1, 32'h100, 32'h1);
    n_checks++;
    if (t_flags !== 5'b00000 || t_cyc !== 32'd49) begin
      n_fail++; $display("FAIL timeout_pre: got flags=%b cyc=%0d want 00000/49", t_flags, t_cyc);
    end
    step(1'b1, 32'h100, 32'h1);
    n_checks++;
    if (t_flags !== 5'b10010) begin n_fail++; $display("FAIL timeout_flags: got %b want 10010", t_flags); end
    n_checks++;
    if (t_cyc !== 32'd50 || t_ret !== 32'd50) begin
      n_fail++; $display("FAIL timeout_counts: got cyc=%0d ret=%0d want 50/50", t_cyc, t_ret);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 32'h44, 32'h1);
    n_checks++;
    if (t_flags !== 5'b10010 || t_cyc !== 32'd50 || t_ret !== 32'd50) begin
      n_fail++; $display("FAIL timeout_frozen: got flags=%b cyc=%0d ret=%0d want 10010/50/50", t_flags, t_cyc, t_ret);
    end
  endtask

  task automatic test_hang();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (h_flags !== 5'b00000) begin n_fail++; $display("FAIL hang_pre: got %b want 00000", h_flags); end
    step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (h_flags !== 5'b10011 || h_cyc !== 32'd8 || h_ret !== 32'd0) begin
      n_fail++; $display("FAIL hang_over_timeout: got flags=%b cyc=%0d ret=%0d want 10011/8/0", h_flags, h_cyc, h_ret);
    end
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h44, 32'h1);
    n_checks++;
    if (h_flags !== 5'b11000 || h_cyc !== 32'd8 || h_ret !== 32'd1) begin
      n_fail++; $display("FAIL hit_over_hang: got flags=%b cyc=%0d ret=%0d want 11000/8/1", h_flags, h_cyc, h_ret);
    end
  endtask

  task automatic test_stall_clear();
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h100, 32'h0);
    for (int i = 0; i < 255; i++) step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (d0_flags !== 5'b00000) begin n_fail++; $display("FAIL stall_pre: got %b want 00000", d0_flags); end
    step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (d0_flags !== 5'b10011 || d0_cyc !== 32'd357 || d0_ret !== 32'd1) begin
      n_fail++; $display("FAIL stall_hang: got flags=%b cyc=%0d ret=%0d want 10011/357/1", d0_flags, d0_cyc, d0_ret);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h100, 32'h0);
    n_checks++;
    if (s_flags !== 5'b00000 || s_cyc !== 4'd15 || s_ret !== 4'd15) begin
      n_fail++; $display("FAIL sat_counts: got flags=%b cyc=%0d ret=%0d want 00000/15/15", s_flags, s_cyc, s_ret);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (s_flags !== 5'b00000) begin n_fail++; $display("FAIL sat_no_hang: got %b want 00000", s_flags); end
    step(1'b1, 32'h44, 32'h1);
    n_checks++;
    if (s_flags !== 5'b11000 || s_ret !== 4'd15) begin
      n_fail++; $display("FAIL sat_pass: got flags=%b ret=%0d want 11000/15", s_flags, s_ret);
    end
  endtask

  task automatic test_reset_recovery();
    do_reset();
    step(1'b1, 32'h44, 32'h1);
    rst = 1'b0;
    #3;
    rst = 1'b1;
    step(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (d0_flags !== 5'b11000 || d0_cyc !== 32'd1) begin
      n_fail++; $display("FAIL async_glitch: got flags=%b cyc=%0d want 11000/1", d0_flags, d0_cyc);
    end
    do_reset();
    n_checks++;
    if (d0_flags !== 5'b00000 || d0_cyc !== 32'd0 || d0_ret !== 32'd0) begin
      n_fail++; $display("FAIL rerun_reset: got flags=%b cyc=%0d ret=%0d want 00000/0/0", d0_flags, d0_cyc, d0_ret);
    end
    step(1'b1, 32'h44, 32'h3);
    n_checks++;
    if (d0_flags !== 5'b10100 || d0_fnum !== 31'd1 || d0_ret !== 32'd1) begin
      n_fail++; $display("FAIL rerun_fail: got flags=%b fnum=%0d ret=%0d want 10100/1/1", d0_flags, d0_fnum, d0_ret);
    end
    do_reset();
    n_checks++;
    if (d0_flags !== 5'b00000 || d0_fnum !== 31'd0) begin
      n_fail++; $display("FAIL fail_cleared: got flags=%b fnum=%0d want 00000/0", d0_flags, d0_fnum);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_hang();
    test_stall_clear();
    test_saturate();
    test_reset_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
